dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (port P)
//  and an external loader/DMA (port L) that preloads or inspects data memory.
//  Sits between the MEM stage and the DataMemory instance and drives the
//  memory's WE/A/WD. Reads from the memory are combinational; writes are synchronous.
//  Port P has priority. Two bounds keep each requester from starving the other:
//  a wait counter limits how long L waits, and a burst cap limits how long L holds the memory.
// PARAMETERS
//  ADDR_W     32  address width (= `INST_SIZE)
//  DATA_W     32  data width (= `INST_SIZE)
//  MAX_WAIT   4   cycles L may wait while P is busy before forced grant (>=1)
//  MAX_BURST  8   L beats allowed while P is waiting before P regains memory (>=1)
// PORTS
//  clk      in   1       clock, all state on posedge
//  rst      in   1       asynchronous reset, active low
//  p_req    in   1       MEM stage needs memory this cycle (load or store)
//  p_we     in   1       MEM stage store enable
//  p_addr   in   ADDR_W  MEM stage address (ALU result)
//  p_wd     in   DATA_W  MEM stage store data
//  p_rd     out  DATA_W  read data to MEM stage (= m_rd)
//  p_stall  out  1       pipeline must hold MEM stage and upstream stages this cycle
//  l_req    in   1       loader beat request
//  l_we     in   1       loader write enable
//  l_addr   in   ADDR_W  loader address
//  l_wd     in   DATA_W  loader write data
//  l_last   in   1       current loader beat is the last one of the burst
//  l_gnt    out  1       loader owns memory; a beat is accepted when l_req&&l_gnt
//  l_rd     out  DATA_W  read data to loader (= m_rd)
//  m_we     out  1       to DataMemory WE
//  m_addr   out  ADDR_W  to DataMemory A
//  m_wd     out  DATA_W  to DataMemory WD
//  m_rd     in   DATA_W  from DataMemory RD (combinational)
// BEHAVIOUR
//  - Reset (rst=0, async): state=PIPE, wait_cnt=0, beat_cnt=0. While rst=0:
//    m_we=0, l_gnt=0, p_stall=0. m_addr and m_wd follow the P port.
//  - State PIPE (owner P): m_addr/m_wd=p_*, m_we=p_req&p_we, p_stall=0, l_gnt=0.
//    * wait_cnt: +1 per cycle with l_req&p_req, saturating at MAX_WAIT. Cleared when l_req=0.
//    * Go to LOAD next cycle when l_req&(!p_req | wait_cnt==MAX_WAIT-1).
//      The P access in the switching cycle still completes. beat_cnt=0 and wait_cnt=0 on entry.
//  - State LOAD (owner L): m_addr/m_wd=l_*, m_we=l_req&l_we, l_gnt=1, p_stall=p_req.
//    * beat_cnt: +1 per accepted beat.
//    * Go to PIPE next cycle on any of:
//      (a) l_req=0;
//      (b) an accepted beat with l_last=1;
//      (c) an accepted beat with beat_cnt==MAX_BURST-1 and p_req=1.
//    * With p_req=0 the burst length is unbounded; beat_cnt saturates at MAX_BURST-1.
//  - Outputs l_gnt and p_stall are decoded from registered state only, so they carry no
//    combinational path from l_req/l_last. Exception: p_stall is gated by p_req.
//  - Latency:
//    * L idle grant: 1 cycle from l_req to l_gnt.
//    * L contended grant: MAX_WAIT cycles.
//    * Reads: same cycle as the owning address. Writes: commit at the next posedge.
//  - l_req dropped in LOAD: one bubble cycle. m_we=0, p_stall=p_req, then PIPE.
//  - Never more than one write per cycle. The non-owner's write enable is ignored.
//  - Reset mid-burst: immediate return to PIPE. An in-flight loader beat is not written.
//    The loader must restart its burst.
//  - Counter widths: $clog2(MAX_WAIT+1) and $clog2(MAX_BURST+1). No wrap; both saturate.
// TESTING
//  1. Hold rst=0 with p_req=1, p_we=1, l_req=1 -> m_we=0, l_gnt=0, p_stall=0.
//     Release rst -> PIPE, and m_addr=p_addr on the first cycle.
//  2. P store addr 0x10 data 0xDEADBEEF, l_req=0 -> m_we=1 that cycle, p_stall=0.
//     The next P load of 0x10 returns p_rd=0xDEADBEEF.
//  3. p_req=0, L writes 0x100/0x104/0x108 with l_last on the 3rd beat
//     -> l_gnt=1 one cycle after l_req and exactly 3 writes.
//     l_gnt=0 the cycle after beat 3.
//  4. p_req=1 continuously, l_req=1 at cycle 0 (MAX_WAIT=4) -> l_gnt=1 at cycle 4.
//     p_stall=1 for every LOAD cycle. P accesses in cycles 0-3 complete.
//  5. p_req=1, L never asserts l_last (MAX_BURST=8) -> exactly 8 beats, then PIPE.
//     Repeat with p_req=0 -> a 12-beat burst runs unbroken.
//  6. Drive rst=0 mid-edge during beat 3 of a write burst -> l_gnt=0 immediately, m_we=0,
//     and beat 3 address unchanged in memory. After release, PIPE with counters=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage (P, priority)
// and an external loader/DMA (L), with a bounded L wait and a bounded L burst under contention.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wd,
  output logic [DATA_W-1:0] p_rd,
  output logic              p_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wd,
  input  logic              l_last,
  output logic              l_gnt,
  output logic [DATA_W-1:0] l_rd,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wd,
  input  logic [DATA_W-1:0] m_rd
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic {
    PIPE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_next;
  logic [BURST_W-1:0] beat_cnt, beat_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PIPE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      beat_cnt <= beat_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    beat_next  = beat_cnt;
    unique case (state)
      PIPE: begin
        if (!l_req) begin
          wait_next = '0;
        end else if (!p_req || wait_cnt == WAIT_LAST) begin
          state_next = LOAD;
          wait_next  = '0;
          beat_next  = '0;
        end else if (wait_cnt != WAIT_SAT) begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      LOAD: begin
        if (!l_req) begin
          state_next = PIPE;
        end else begin
          // Beat accepted this cycle; the burst cap only bites while P is waiting.
          if (l_last || (beat_cnt == BURST_LAST && p_req)) state_next = PIPE;
          if (beat_cnt != BURST_LAST) beat_next = beat_cnt + 1'b1;
        end
      end
      default: state_next = PIPE;
    endcase
  end

  always_comb begin
    m_addr  = p_addr;
    m_wd    = p_wd;
    m_we    = p_req & p_we;
    l_gnt   = 1'b0;
    p_stall = 1'b0;
    if (state == LOAD) begin
      m_addr  = l_addr;
      m_wd    = l_wd;
      m_we    = l_req & l_we;
      l_gnt   = 1'b1;
      p_stall = p_req;
    end
    // Reset also kills any in-flight write, including one already driven this cycle.
    if (!rst) m_we = 1'b0;
  end

  assign p_rd = m_rd;
  assign l_rd = m_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural single-port memory
// (combinational read, posedge write) attached to the m_* port.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p_req, p_we;
  logic [31:0] p_addr, p_wd, p_rd;
  logic        p_stall;
  logic        l_req, l_we, l_last, l_gnt;
  logic [31:0] l_addr, l_wd, l_rd;
  logic        m_we;
  logic [31:0] m_addr, m_wd, m_rd;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  bit [31:0] mem [0:1023];

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wd(p_wd), .p_rd(p_rd), .p_stall(p_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wd(l_wd), .l_last(l_last),
    .l_gnt(l_gnt), .l_rd(l_rd),
    .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb m_rd = mem[m_addr[11:2]];

  always @(posedge clk) begin
    if (m_we === 1'b1) begin
      mem[m_addr[11:2]] <= m_wd;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    int beats;

    // 1. Reset held with every request active
    rst = 1'b0;
    p_req = 1'b1; p_we = 1'b1; p_addr = 32'h20; p_wd = 32'h55;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h200; l_wd = 32'h66; l_last = 1'b0;
    #2;
    check("rst_m_we", {31'b0, m_we}, 32'd0);
    check("rst_l_gnt", {31'b0, l_gnt}, 32'd0);
    check("rst_p_stall", {31'b0, p_stall}, 32'd0);
    check("rst_m_addr", m_addr, 32'h20);
    tick();
    tick();
    p_req = 1'b0; l_req = 1'b0; p_addr = 32'h44;
    rst = 1'b1;
    #1;
    check("post_rst_l_gnt", {31'b0, l_gnt}, 32'd0);
    check("post_rst_m_addr", m_addr, 32'h44);
    tick();

    // 2. P store then load
    p_req = 1'b1; p_we = 1'b1; p_addr = 32'h10; p_wd = 32'hDEADBEEF;
    #1;
    check("p_store_m_we", {31'b0, m_we}, 32'd1);
    check("p_store_stall", {31'b0, p_stall}, 32'd0);
    tick();
    p_we = 1'b0;
    #1;
    check("p_load_rd", p_rd, 32'hDEADBEEF);
    tick();

    // 3. Uncontended 3-beat loader write burst
    p_req = 1'b0;
    base = wr_cnt;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wd = 32'hA0; l_last = 1'b0;
    #1;
    check("l_idle_gnt_c0", {31'b0, l_gnt}, 32'd0);
    tick();
    #1;
    check("l_idle_gnt_c1", {31'b0, l_gnt}, 32'd1);
    check("l_beat1_addr", m_addr, 32'h100);
    check("l_beat1_we", {31'b0, m_we}, 32'd1);
    tick();
    l_addr = 32'h104; l_wd = 32'hA1;
    #1;
    check("l_beat2_addr", m_addr, 32'h104);
    tick();
    l_addr = 32'h108; l_wd = 32'hA2; l_last = 1'b1;
    #1;
    check("l_beat3_we", {31'b0, m_we}, 32'd1);
    tick();
    l_req = 1'b0; l_last = 1'b0; l_we = 1'b0;
    #1;
    check("l_after_last_gnt", {31'b0, l_gnt}, 32'd0);
    check("l_burst_writes", 32'(wr_cnt - base), 32'd3);
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h104;
    #1;
    check("l_burst_data", p_rd, 32'hA1);
    tick();

    // 4. Contended grant after MAX_WAIT cycles, P stores complete meanwhile
    p_we = 1'b1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h100; l_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p_addr = 32'h300 + 32'(4 * k); p_wd = 32'hC0 + 32'(k);
      #1;
      check("cont_wait_gnt", {31'b0, l_gnt}, 32'd0);
      check("cont_wait_stall", {31'b0, p_stall}, 32'd0);
      check("cont_wait_p_we", {31'b0, m_we}, 32'd1);
      tick();
    end
    p_addr = 32'h310; p_wd = 32'hBAD;
    #1;
    check("cont_gnt_c4", {31'b0, l_gnt}, 32'd1);
    check("cont_stall_c4", {31'b0, p_stall}, 32'd1);
    check("cont_blocked_p_we", {31'b0, m_we}, 32'd0);
    check("cont_l_rd", l_rd, 32'hA0);
    tick();
    l_req = 1'b0; l_last = 1'b0;
    #1;
    check("cont_back_gnt", {31'b0, l_gnt}, 32'd0);
    check("cont_back_stall", {31'b0, p_stall}, 32'd0);
    p_we = 1'b0; p_addr = 32'h30C;
    #1;
    check("cont_p_store_c3", p_rd, 32'hC3);
    tick();
    p_addr = 32'h310;
    #1;
    check("cont_ignored_write", p_rd, 32'h0);
    tick();

    // 5a. Burst cap with P waiting
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h0;
    l_req = 1'b1; l_we = 1'b1; l_last = 1'b0; l_addr = 32'h400; l_wd = 32'hF00;
    base = wr_cnt;
    n = 0;
    while (!l_gnt && n < 10) begin tick(); n++; end
    check("cap_grant_latency", 32'(n), 32'd4);
    beats = 0;
    while (l_gnt && beats < 20) begin
      l_addr = 32'h400 + 32'(4 * beats); l_wd = 32'hF00 + 32'(beats);
      beats++;
      tick();
    end
    l_req = 1'b0;
    #1;
    check("cap_beats", 32'(beats), 32'd8);
    check("cap_writes", 32'(wr_cnt - base), 32'd8);
    check("cap_stall_released", {31'b0, p_stall}, 32'd0);
    tick();

    // 5b. Unbounded burst with P idle
    p_req = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_last = 1'b0; l_addr = 32'h500; l_wd = 32'hF00;
    base = wr_cnt;
    n = 0;
    while (!l_gnt && n < 10) begin tick(); n++; end
    check("long_grant_latency", 32'(n), 32'd1);
    beats = 0;
    while (l_gnt && beats < 20) begin
      l_addr = 32'h500 + 32'(4 * beats); l_wd = 32'hF00 + 32'(beats);
      l_last = (beats == 11);
      beats++;
      tick();
    end
    l_req = 1'b0; l_last = 1'b0;
    check("long_beats", 32'(beats), 32'd12);
    check("long_writes", 32'(wr_cnt - base), 32'd12);
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h52C;
    #1;
    check("long_last_data", p_rd, 32'hF0B);
    tick();

    // 6. Reset asserted mid-cycle during beat 3 of a write burst
    p_req = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_last = 1'b0; l_addr = 32'h600; l_wd = 32'hE0;
    tick();
    tick();
    l_addr = 32'h604; l_wd = 32'hE1;
    tick();
    l_addr = 32'h608; l_wd = 32'hE2;
    #1;
    check("mid_rst_pre_we", {31'b0, m_we}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", {31'b0, l_gnt}, 32'd0);
    check("mid_rst_m_we", {31'b0, m_we}, 32'd0);
    tick();
    l_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_after_gnt", {31'b0, l_gnt}, 32'd0);
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h608;
    #1;
    check("mid_rst_beat3_unwritten", p_rd, 32'h0);
    tick();
    p_addr = 32'h604;
    #1;
    check("mid_rst_beat2_written", p_rd, 32'hE1);
    tick();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h700; l_wd = 32'h77;
    n = 0;
    while (!l_gnt && n < 10) begin tick(); n++; end
    check("mid_rst_wait_cleared", 32'(n), 32'd4);
    l_req = 1'b0;
    #1;
    check("bubble_gnt", {31'b0, l_gnt}, 32'd1);
    check("bubble_stall", {31'b0, p_stall}, 32'd1);
    check("bubble_m_we", {31'b0, m_we}, 32'd0);
    tick();
    check("bubble_exit_gnt", {31'b0, l_gnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
